// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types, constants and GF(2^8) helpers for the AES-256
// decryption datapath.
//   state_t : 128-bit AES state viewed as four 32-bit columns
//             (index 3 = column 0 = bits [127:96], index 0 = column 3)
//   col_t   : one 32-bit column, byte 0 in the MSBs
//   xtime / gmul09 / gmul0b / gmul0d / gmul0e : multiplies in GF(2^8) mod 0x11b
package aes_dec_pkg;

  typedef logic [3:0][31:0] state_t;
  typedef logic [31:0]      col_t;

  // Column indices in transfer order
  localparam logic [1:0] COL0 = 2'd0;
  localparam logic [1:0] COL1 = 2'd1;
  localparam logic [1:0] COL2 = 2'd2;
  localparam logic [1:0] COL3 = 2'd3;

  // Stage FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COL   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Column 0 sits in the top word, so the packed index is the bit-inverse
  // of the column number.
  function automatic logic [1:0] col_idx(input logic [1:0] col);
    return ~col;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_col.sv
// inv_mix_col: combinational InvMixColumns of a single 32-bit column.
//   col_in  : input column, byte 0 in [31:24]
//   col_out : column multiplied by the {0e,0b,0d,09} circulant matrix
module inv_mix_col
  import aes_dec_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] b0, b1, b2, b3;

  assign b0 = col_in[31:24];
  assign b1 = col_in[23:16];
  assign b2 = col_in[15:8];
  assign b3 = col_in[7:0];

  assign col_out[31:24] = gmul0e(b0) ^ gmul0b(b1) ^ gmul0d(b2) ^ gmul09(b3);
  assign col_out[23:16] = gmul09(b0) ^ gmul0e(b1) ^ gmul0b(b2) ^ gmul0d(b3);
  assign col_out[15:8]  = gmul0d(b0) ^ gmul09(b1) ^ gmul0e(b2) ^ gmul0b(b3);
  assign col_out[7:0]   = gmul0b(b0) ^ gmul0d(b1) ^ gmul09(b2) ^ gmul0e(b3);

endmodule

// File: rtl/inv_addkey_mix_stage.sv
// inv_addkey_mix_stage: column-serial AddRoundKey + InvMixColumns for the
// AES-256 decryption round. One column per cycle through a single shared
// inv_mix_col instance; result presented under valid/ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready high only when idle)
//   state_in, key_in    : 128-bit state and round key, column 0 = [127:96]
//   bypass_mix          : 1 = result is state_in ^ key_in (no InvMixColumns)
//   out_valid/out_ready : output handshake, out_data held until accepted
//   out_data            : 128-bit result
//   busy                : column processing in progress
// Optional macro INV_MIX_COL_REG_EN: registers the XOR result before the
// InvMix logic, adding one drain cycle (accept-to-valid 5 instead of 4).
module inv_addkey_mix_stage
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic         bypass_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  logic [1:0] fsm;
  logic [1:0] col_cnt;
  state_t     st_q;
  state_t     key_q;
  logic       byp_q;
  state_t     res_q;

  col_t       x;
  col_t       mix_in;
  col_t       mixed;
  logic       wr_en;
  logic [1:0] wr_col;
  col_t       wr_val;

  assign x = st_q[col_idx(col_cnt)] ^ key_q[col_idx(col_cnt)];

  inv_mix_col u_inv_mix_col (
    .col_in  (mix_in),
    .col_out (mixed)
  );

`ifdef INV_MIX_COL_REG_EN
  col_t       x_q;
  logic       pipe_vld;
  logic [1:0] pipe_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      pipe_vld <= 1'b0;
      pipe_col <= COL0;
    end else begin
      x_q      <= x;
      pipe_vld <= (fsm == ST_COL);
      pipe_col <= col_cnt;
    end
  end

  assign mix_in = x_q;
  assign wr_en  = pipe_vld;
  assign wr_col = pipe_col;
  assign wr_val = byp_q ? x_q : mixed;
`else
  assign mix_in = x;
  assign wr_en  = (fsm == ST_COL);
  assign wr_col = col_cnt;
  assign wr_val = byp_q ? x : mixed;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= ST_IDLE;
      col_cnt <= COL0;
      st_q    <= '0;
      key_q   <= '0;
      byp_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid) begin
            st_q    <= state_in;
            key_q   <= key_in;
            byp_q   <= bypass_mix;
            col_cnt <= COL0;
            fsm     <= ST_COL;
          end
        end
        ST_COL: begin
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == COL3) begin
`ifdef INV_MIX_COL_REG_EN
            fsm <= ST_DRAIN;
`else
            fsm <= ST_DONE;
`endif
          end
        end
        ST_DRAIN: fsm <= ST_DONE;
        ST_DONE: begin
          if (out_ready) fsm <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase

      if (wr_en) res_q[col_idx(wr_col)] <= wr_val;
    end
  end

  assign in_ready  = (fsm == ST_IDLE);
  assign out_valid = (fsm == ST_DONE);
  assign busy      = (fsm == ST_COL) || (fsm == ST_DRAIN);
  assign out_data  = res_q;

endmodule

// File: tb/tb_inv_addkey_mix_stage.sv
module tb_inv_addkey_mix_stage;

`ifdef INV_MIX_COL_REG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int PERIOD = LAT + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic [127:0] key_in = '0;
  logic         bypass_mix = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inv_addkey_mix_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .key_in     (key_in),
    .bypass_mix (bypass_mix),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  // Reference: generic shift-and-add GF(2^8) product, then matrix by rows.
  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] st, input logic [127:0] key,
                                             input logic byp);
    logic [7:0] m [4][4];
    logic [7:0] s [16];
    logic [7:0] r [16];
    logic [127:0] x, res;
    m[0] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    m[1] = '{8'h09, 8'h0e, 8'h0b, 8'h0d};
    m[2] = '{8'h0d, 8'h09, 8'h0e, 8'h0b};
    m[3] = '{8'h0b, 8'h0d, 8'h09, 8'h0e};
    x = st ^ key;
    for (int i = 0; i < 16; i++) s[i] = x[127 - 8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        r[4*c + row] = 8'h00;
        for (int k = 0; k < 4; k++) r[4*c + row] ^= ref_gmul(m[row][k], s[4*c + k]);
      end
    if (byp) return x;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = r[i];
    return res;
  endfunction

  // Accept one block (assumes idle) and wait for out_valid; lat = -1 on timeout.
  task automatic send(input logic [127:0] st, input logic [127:0] key, input logic byp,
                      output int lat);
    state_in = st;
    key_in = key;
    bypass_mix = byp;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    key_in = {$urandom, $urandom, $urandom, $urandom};
    bypass_mix = ~byp;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_data=%h, required 1 0 0 0",
               in_ready, out_valid, busy, out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vector;
    int lat;
    logic [127:0] exp;
    exp = 128'hdb135345_f20a225c_01010101_2d26314c;
    send(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, '0, 1'b0, lat);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL vector_latency: got %0d required %0d", lat, LAT);
    end
    n_checks++;
    if (out_data !== exp) begin
      n_fail++;
      $display("FAIL vector_data: got %h required %h", out_data, exp);
    end
    drain_out();
  endtask

  task automatic test_key_cancel;
    int lat;
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    send(v, v, 1'b0, lat);
    n_checks++;
    if (lat !== LAT || out_data !== '0) begin
      n_fail++;
      $display("FAIL key_cancel: lat=%0d data=%h required lat=%0d data=0", lat, out_data, LAT);
    end
    drain_out();
  endtask

  task automatic test_bypass;
    int lat;
    logic [127:0] exp;
    exp = 128'h00102030_40506070_8090a0b0_c0d0e0f0;
    send(128'h00112233_44556677_8899aabb_ccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
         1'b1, lat);
    n_checks++;
    if (lat !== LAT || out_data !== exp) begin
      n_fail++;
      $display("FAIL bypass: lat=%0d data=%h required lat=%0d data=%h", lat, out_data, LAT, exp);
    end
    drain_out();
  endtask

  task automatic test_random;
    int lat;
    logic [127:0] st, key, exp;
    logic byp;
    for (int i = 0; i < 8; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      byp = ($urandom_range(0, 3) == 0);
      exp = ref_block(st, key, byp);
      send(st, key, byp, lat);
      n_checks++;
      if (lat !== LAT || out_data !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: lat=%0d data=%h required lat=%0d data=%h",
                 i, lat, out_data, LAT, exp);
      end
      drain_out();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [127:0] st, key, exp;
    st = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_block(st, key, 1'b0);
    send(st, key, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        in_valid = 1'b1;
        state_in = ~st;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b data=%h required 1 0 %h",
                 i, out_valid, in_ready, out_data, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1",
               out_valid, in_ready);
    end
    // The pulsed in_valid must not have started a second transaction.
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_no_accept: busy=%b in_ready=%b required 0 1", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [127:0] exp;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    key_in = {$urandom, $urandom, $urandom, $urandom};
    bypass_mix = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;       // accept, col_cnt = 0
    in_valid = 1'b0;
    repeat (2) @(posedge clk); // col_cnt = 2
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b busy=%b data=%h required 0 1 0 0",
               out_valid, in_ready, busy, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp = 128'hdb135345_f20a225c_01010101_2d26314c;
    send(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, '0, 1'b0, lat);
    n_checks++;
    if (lat !== LAT || out_data !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_recover: lat=%0d data=%h required lat=%0d data=%h",
               lat, out_data, LAT, exp);
    end
    drain_out();
  endtask

  task automatic test_back_to_back;
    logic [127:0] sts [3];
    logic [127:0] keys [3];
    logic         byps [3];
    logic [127:0] exps [3];
    int acc_t [3];
    int nacc, nout, cyc;
    logic acc_now, xfer_now;
    for (int i = 0; i < 3; i++) begin
      sts[i] = {$urandom, $urandom, $urandom, $urandom};
      keys[i] = {$urandom, $urandom, $urandom, $urandom};
      byps[i] = (i == 1);
      exps[i] = ref_block(sts[i], keys[i], byps[i]);
      acc_t[i] = -100;
    end
    nacc = 0;
    nout = 0;
    cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    state_in = sts[0];
    key_in = keys[0];
    bypass_mix = byps[0];
    while (nout < 3 && cyc < 60) begin
      acc_now = in_valid & in_ready;
      xfer_now = out_valid;
      if (xfer_now) begin
        n_checks++;
        if (out_data !== exps[nout]) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: got %h required %h", nout, out_data, exps[nout]);
        end
        nout++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        acc_t[nacc] = cyc;
        nacc++;
        if (nacc < 3) begin
          state_in = sts[nacc];
          key_in = keys[nacc];
          bypass_mix = byps[nacc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (nout !== 3 || nacc !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: outputs=%0d accepts=%0d required 3 3", nout, nacc);
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (acc_t[i] - acc_t[i-1] !== PERIOD) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: got %0d required %0d", i, acc_t[i] - acc_t[i-1], PERIOD);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_vector();
    test_key_cancel();
    test_bypass();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
